// File: rtl/hipercubo_mm_seq.sv
// ---------------------------------------------------------------------------
// hipercubo_mm_seq
//
// 2x2 matrix multiplier mapped onto a 3-dimensional hypercube of 8 processing
// nodes, with its own sequencer. One multiply takes four rising edges from
// the START-accept edge to the edge that updates the result matrix:
//   accept : every node loads its A/B coefficient
//   XFER   : one hop of neighbour transfers along hypercube links
//   MUL    : every node registers Rc = Ra * Rb
//   SUM    : MTXij <= Rc0ij + Rc1ij (optionally plus the old MTXij)
// DONE is a one-cycle pulse in the cycle after the SUM edge. The result
// matrix is registered and held between operations.
//
// Node numbering: node index n = {k, i, j}. Plane k = 0 computes
// A[i][0]*B[0][j] and plane k = 1 computes A[i][1]*B[1][j].
//
// Parameters:
//   W   coefficient width (A and B elements)
//   OW  result width; must satisfy OW >= 2W+1. Accumulation wraps mod 2^OW.
//
// Optional build macro:
//   HIPERCUBO_SIGNED_EN  when defined, coefficients, products, sums and
//                        results are two's complement (sign-extended);
//                        otherwise all arithmetic is unsigned.
//
// Ports:
//   CLK                  in   master clock, rising edge
//   RST                  in   synchronous active-high reset, overrides START
//   START                in   request a multiply, sampled only in IDLE
//   ACC                  in   sampled with START: 1 = C <= C + A*B, 0 = C <= A*B
//   A00,A01,A10,A11      in   matrix A, sampled on the accept edge
//   B00,B01,B10,B11      in   matrix B, sampled on the accept edge
//   BUSY                 out  high while an operation is in flight
//   DONE                 out  one-cycle pulse, MTX updated in that cycle
//   MTX00,MTX01,MTX10,MTX11 out  registered result matrix C
// ---------------------------------------------------------------------------
module hipercubo_mm_seq #(
    parameter int W  = 4,
    parameter int OW = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          ACC,
    input  logic [W-1:0]  A00,
    input  logic [W-1:0]  A01,
    input  logic [W-1:0]  A10,
    input  logic [W-1:0]  A11,
    input  logic [W-1:0]  B00,
    input  logic [W-1:0]  B01,
    input  logic [W-1:0]  B10,
    input  logic [W-1:0]  B11,
    output logic          BUSY,
    output logic          DONE,
    output logic [OW-1:0] MTX00,
    output logic [OW-1:0] MTX01,
    output logic [OW-1:0] MTX10,
    output logic [OW-1:0] MTX11
);

    // The LOAD step has no state of its own: it is the IDLE edge that
    // accepts START, so the machine moves straight from IDLE to XFER.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_MUL  = 2'd2,
        S_SUM  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic   w_load;
    logic   w_xfer;
    logic   w_mul;
    logic   w_sum;
    logic   w_busy_next;
    logic   w_done_next;

    logic   r_busy;
    logic   r_done;
    logic   r_acc;

    // Coefficient inputs gathered into arrays indexed by {i, j}
    logic [W-1:0]   w_a_in [4];
    logic [W-1:0]   w_b_in [4];

    // Node registers, indexed by {k, i, j}
    logic [W-1:0]   r_ra [8];
    logic [W-1:0]   r_rb [8];
    logic [2*W-1:0] r_rc [8];

    logic [W-1:0]   w_ra_next [8];
    logic [W-1:0]   w_rb_next [8];
    logic [2*W-1:0] w_rc_next [8];

    // Result matrix, indexed by {i, j}
    logic [OW-1:0]  r_mtx      [4];
    logic [OW-1:0]  w_sum_val  [4];
    logic [OW-1:0]  w_mtx_next [4];

    assign w_a_in[0] = A00;
    assign w_a_in[1] = A01;
    assign w_a_in[2] = A10;
    assign w_a_in[3] = A11;
    assign w_b_in[0] = B00;
    assign w_b_in[1] = B01;
    assign w_b_in[2] = B10;
    assign w_b_in[3] = B11;

    // -----------------------------------------------------------------------
    // Sequencer: next state and step strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        w_mul        = 1'b0;
        w_sum        = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_load       = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = S_XFER;
                end
            end
            S_XFER: begin
                w_xfer       = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = S_MUL;
            end
            S_MUL: begin
                w_mul        = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = S_SUM;
            end
            S_SUM: begin
                // BUSY falls and DONE rises on the same edge that writes MTX
                w_sum        = 1'b1;
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Processing nodes
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_node
            // Cell {i, j} this node serves, and its plane k
            localparam int CELL = gi % 4;
            // A source {k, i, k}: differs from this node at most in bit j,
            // so it is this node itself or its neighbour along the j link.
            localparam int SRC_A = (gi & 6) | ((gi >> 2) & 1);
            // B source {k, k, j}: differs at most in bit i (the i link).
            localparam int SRC_B = (gi & 5) | (((gi >> 2) & 1) << 1);

            logic [2*W-1:0] w_prod;

`ifdef HIPERCUBO_SIGNED_EN
            assign w_prod = $signed({{W{r_ra[gi][W-1]}}, r_ra[gi]})
                          * $signed({{W{r_rb[gi][W-1]}}, r_rb[gi]});
`else
            assign w_prod = {{W{1'b0}}, r_ra[gi]} * {{W{1'b0}}, r_rb[gi]};
`endif

            // Both planes load the full matrices on accept; the XFER hop
            // then leaves plane k holding column k of A and row k of B.
            assign w_ra_next[gi] = w_load ? w_a_in[CELL]
                                 : (w_xfer ? r_ra[SRC_A] : r_ra[gi]);
            assign w_rb_next[gi] = w_load ? w_b_in[CELL]
                                 : (w_xfer ? r_rb[SRC_B] : r_rb[gi]);
            assign w_rc_next[gi] = w_mul ? w_prod : r_rc[gi];
        end

        // Reduction across the k dimension: cell {i, j} adds the products of
        // node 0ij and node 1ij. OW >= 2W+1 keeps this sum from overflowing.
        for (gi = 0; gi < 4; gi++) begin : g_cell
            logic [2*W-1:0] w_rc0;
            logic [2*W-1:0] w_rc1;
            logic [OW-1:0]  w_ext0;
            logic [OW-1:0]  w_ext1;

            assign w_rc0 = r_rc[gi];
            assign w_rc1 = r_rc[gi + 4];

`ifdef HIPERCUBO_SIGNED_EN
            assign w_ext0 = {{(OW-2*W){w_rc0[2*W-1]}}, w_rc0};
            assign w_ext1 = {{(OW-2*W){w_rc1[2*W-1]}}, w_rc1};
`else
            assign w_ext0 = {{(OW-2*W){1'b0}}, w_rc0};
            assign w_ext1 = {{(OW-2*W){1'b0}}, w_rc1};
`endif

            assign w_sum_val[gi]  = w_ext0 + w_ext1;
            // Accumulation simply wraps at OW bits
            assign w_mtx_next[gi] = r_acc ? (r_mtx[gi] + w_sum_val[gi])
                                          : w_sum_val[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                r_ra[n] <= '0;
                r_rb[n] <= '0;
                r_rc[n] <= '0;
            end
            for (int c = 0; c < 4; c++) begin
                r_mtx[c] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            if (w_load) begin
                r_acc <= ACC;
            end
            for (int n = 0; n < 8; n++) begin
                r_ra[n] <= w_ra_next[n];
                r_rb[n] <= w_rb_next[n];
                r_rc[n] <= w_rc_next[n];
            end
            if (w_sum) begin
                for (int c = 0; c < 4; c++) begin
                    r_mtx[c] <= w_mtx_next[c];
                end
            end
        end
    end

    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign MTX00 = r_mtx[0];
    assign MTX01 = r_mtx[1];
    assign MTX10 = r_mtx[2];
    assign MTX11 = r_mtx[3];

endmodule

// File: tb/tb_hipercubo_mm_seq.sv
// ---------------------------------------------------------------------------
// Testbench for hipercubo_mm_seq (W=4, OW=10). Table-driven single
// operations followed by hand-written multi-cycle sequences: back-to-back
// START, ignored START while busy, reset abort, ACC after reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hipercubo_mm_seq;

    localparam int W  = 4;
    localparam int OW = 10;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          ACC;
    logic [W-1:0]  A00, A01, A10, A11;
    logic [W-1:0]  B00, B01, B10, B11;
    logic          BUSY;
    logic          DONE;
    logic [OW-1:0] MTX00, MTX01, MTX10, MTX11;

    int checks = 0;
    int errors = 0;

    hipercubo_mm_seq #(.W(W), .OW(OW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ACC   (ACC),
        .A00   (A00), .A01 (A01), .A10 (A10), .A11 (A11),
        .B00   (B00), .B01 (B01), .B10 (B10), .B11 (B11),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .MTX00 (MTX00), .MTX01 (MTX01), .MTX10 (MTX10), .MTX11 (MTX11)
    );

    always #5 CLK = ~CLK;

    // a/b packed as {x00, x01, x10, x11}; exp as {C00, C01, C10, C11}
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        acc;
        logic [39:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ab(input logic [15:0] a, input logic [15:0] b);
        {A00, A01, A10, A11} = a;
        {B00, B01, B10, B11} = b;
    endtask

    task automatic check_mtx(input string name, input logic [39:0] e);
        check({name, "_mtx00"}, 32'(MTX00), 32'(e[39:30]));
        check({name, "_mtx01"}, 32'(MTX01), 32'(e[29:20]));
        check({name, "_mtx10"}, 32'(MTX10), 32'(e[19:10]));
        check({name, "_mtx11"}, 32'(MTX11), 32'(e[9:0]));
    endtask

    // One START pulse, then scrambled inputs; measures latency and BUSY length
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic acc, input logic [39:0] e);
        int lat;
        int busy_cnt;
        @(negedge CLK);
        set_ab(a, b);
        ACC   = acc;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        set_ab(16'($urandom), 16'($urandom));
        ACC   = ~acc;
        lat      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge CLK);
            if (DONE === 1'b1) begin
                lat = c;
                break;
            end
            if (BUSY === 1'b1) busy_cnt++;
        end
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
        check({name, "_busy_at_done"}, 32'(BUSY), 32'd0);
        check_mtx(name, e);
        $display("op %s: a=%04h b=%04h acc=%0b -> %0h %0h %0h %0h latency=%0d",
                 name, a, b, acc, MTX00, MTX01, MTX10, MTX11, lat);
    endtask

    vec_t  tbl [6];
    string names [6];
    int    nv;

    initial begin
`ifdef HIPERCUBO_SIGNED_EN
        nv = 4;
        tbl[0] = '{a: 16'h8888, b: 16'h8888, acc: 1'b0, exp: {10'd128, 10'd128, 10'd128, 10'd128}};
        names[0] = "s_all_neg8";
        tbl[1] = '{a: 16'hF00F, b: 16'h3456, acc: 1'b0, exp: {10'h3FD, 10'h3FC, 10'h3FB, 10'h3FA}};
        names[1] = "s_neg_identity";
        tbl[2] = '{a: 16'hF00F, b: 16'h3456, acc: 1'b1, exp: {10'h3FA, 10'h3F8, 10'h3F6, 10'h3F4}};
        names[2] = "s_neg_identity_acc";
        tbl[3] = '{a: 16'h7812, b: 16'h7781, acc: 1'b0, exp: {10'd113, 10'd41, 10'h3F7, 10'd9}};
        names[3] = "s_mixed";
        tbl[4] = '0; names[4] = "";
        tbl[5] = '0; names[5] = "";
`else
        nv = 6;
        tbl[0] = '{a: 16'h1234, b: 16'h5678, acc: 1'b0, exp: {10'd19, 10'd22, 10'd43, 10'd50}};
        names[0] = "basic";
        tbl[1] = '{a: 16'hFFFF, b: 16'hFFFF, acc: 1'b0, exp: {10'd450, 10'd450, 10'd450, 10'd450}};
        names[1] = "all15";
        tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, acc: 1'b1, exp: {10'd900, 10'd900, 10'd900, 10'd900}};
        names[2] = "all15_acc";
        tbl[3] = '{a: 16'hFFFF, b: 16'hFFFF, acc: 1'b1, exp: {10'd326, 10'd326, 10'd326, 10'd326}};
        names[3] = "all15_acc_wrap";
        tbl[4] = '{a: 16'h0F71, b: 16'h3029, acc: 1'b0, exp: {10'd30, 10'd135, 10'd23, 10'd9}};
        names[4] = "mixed";
        tbl[5] = '{a: 16'h1001, b: 16'h1111, acc: 1'b1, exp: {10'd31, 10'd136, 10'd24, 10'd10}};
        names[5] = "mixed_acc";
`endif

        // Reset, with START held high to show reset wins
        RST   = 1'b1;
        START = 1'b1;
        ACC   = 1'b0;
        set_ab(16'h0000, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check_mtx("reset", 40'd0);
        RST   = 1'b0;
        START = 1'b0;
        $display("reset: busy=%0b done=%0b mtx=%0h %0h %0h %0h", BUSY, DONE, MTX00, MTX01, MTX10, MTX11);

        // Table-driven single operations
        for (int v = 0; v < nv; v++) begin
            run_op(names[v], tbl[v].a, tbl[v].b, tbl[v].acc, tbl[v].exp);
        end

        // Back-to-back: START held high, identity * [[2,3],[4,5]]
        @(negedge CLK);
        set_ab(16'h1001, 16'h2345);
        ACC   = 1'b0;
        START = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            check($sformatf("b2b_done_c%0d", c), 32'(DONE), 32'((c % 4) == 0));
            if ((c % 4) == 0) begin
                check_mtx($sformatf("b2b_c%0d", c), {10'd2, 10'd3, 10'd4, 10'd5});
                $display("b2b result at cycle %0d: %0h %0h %0h %0h", c, MTX00, MTX01, MTX10, MTX11);
            end
        end
        START = 1'b0;

        // START re-pulsed during XFER and MUL with other operands: ignored
        @(negedge CLK);
        set_ab(16'h1234, 16'h5671);
        ACC   = 1'b0;
        START = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                set_ab(16'h7777, 16'h7777);
                ACC   = 1'b1;
                START = 1'b1;
            end else if (c == 2) begin
                set_ab(16'h3333, 16'h2222);
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            check($sformatf("ignore_done_c%0d", c), 32'(DONE), 32'(c == 4));
        end
        check_mtx("ignore", {10'd19, 10'd8, 10'd43, 10'd22});
        $display("ignore: mtx=%0h %0h %0h %0h", MTX00, MTX01, MTX10, MTX11);

        // Reset during the MUL cycle aborts the operation
        @(negedge CLK);
        set_ab(16'h1001, 16'h2345);
        ACC   = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check_mtx("abort", 40'd0);
        for (int c = 4; c <= 10; c++) begin
            @(negedge CLK);
            check($sformatf("abort_no_done_c%0d", c), 32'(DONE), 32'd0);
        end
        $display("abort: busy=%0b mtx=%0h %0h %0h %0h", BUSY, MTX00, MTX01, MTX10, MTX11);

        // ACC=1 on the first operation after reset adds to zero
        run_op("acc_after_reset", 16'h1234, 16'h5671, 1'b1, {10'd19, 10'd8, 10'd43, 10'd22});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hipercubo_mm_seq.md
Name: hipercubo_mm_seq

Overview:
- 2x2 matrix multiplier on a 3-dimensional hypercube of 8 processing nodes, with a built-in sequencer.
- Successor to the externally-sequenced hypercube multiplier. The internal FSM replaces the external ENa/ENb/ENc/SEL buses.
- Coefficient and result widths are parametrised. Adds a START/BUSY/DONE handshake and an accumulate mode (C <= C + A*B).
- Sits between the coefficient source and the result consumer in the matrix datapath.

Parameters:
- W, 4, coefficient width in bits (A and B elements).
- OW, 10, result width in bits; must satisfy OW >= 2W+1; accumulation wraps modulo 2^OW.

Ports:
- CLK  in  1  master clock; all state changes on the rising edge.
- RST  in  1  master reset, synchronous, active-high.
- START  in  1  request a multiply; sampled only in IDLE.
- ACC  in  1  sampled with START; 1 = add the product to the current MTX outputs, 0 = overwrite them.
- A00,A01,A10,A11  in  W each  matrix A coefficients; sampled on the START-accept edge.
- B00,B01,B10,B11  in  W each  matrix B coefficients; sampled on the START-accept edge.
- BUSY  out  1  high while an operation is in flight.
- DONE  out  1  one-cycle pulse; MTX outputs are valid and updated in that cycle.
- MTX00,MTX01,MTX10,MTX11  out  OW each  result matrix C, registered; held between operations.

Behaviour:
- Reset, when RST=1 at an edge:
  - State goes to IDLE.
  - BUSY=0, DONE=0, all MTX=0.
  - All node registers Ra/Rb (W bits) and Rc (2W bits) cleared.
  - The latched ACC flag is cleared.
  - RST overrides START. Reset mid-operation aborts it: no DONE is produced.
- FSM states: IDLE -> LOAD -> XFER -> MUL -> SUM -> IDLE.
- IDLE, START=1 at an edge:
  - Node 0ij captures Ra=A[i][j], Rb=B[i][j].
  - ACC is latched.
  - State goes to XFER; BUSY=1 from this edge.
- XFER: one cycle of neighbour transfers along hypercube links. After it, each node holds:
  - node 0ij: A[i][0] and B[0][j];
  - node 1ij: A[i][1] and B[1][j].
- MUL: all 8 nodes register Rc = Ra*Rb (2W bits, unsigned).
- SUM: MTXij <= Rc0ij + Rc1ij, zero-extended to OW. If ACC was latched, the old MTXij is also added, modulo 2^OW.
  - DONE=1 during the following cycle; BUSY=0 on the same edge.
  - State returns to IDLE.
  - (The LOAD state is the IDLE capture edge itself.)
- Latency: DONE is high in the cycle starting 4 rising edges after the START-accept edge. Edges: accept, XFER, MUL, SUM.
- Back-to-back: START may be asserted while DONE=1. It is accepted (state is IDLE), giving one result every 4 cycles.
- START while BUSY=1 is ignored. It is not queued, and A/B/ACC are not resampled.
- MTX outputs change only on the SUM edge or on reset.
- A/B inputs may change freely after the accept edge.
- ACC=1 on the first operation after reset adds to 0.

Optional Feature:
- Macro HIPERCUBO_SIGNED_EN.
- Defined:
  - Coefficients are two's complement.
  - Products are signed 2W-bit values.
  - Sums are sign-extended to OW.
  - MTX outputs are two's complement and accumulation wraps modulo 2^OW.
- Undefined: all arithmetic is unsigned and zero-extended, as described above.

Test Plan:
- Reset then A=[[1,2],[3,4]], B=[[5,6],[7,8]], START=1 for one cycle, ACC=0 -> BUSY high 3 cycles; DONE pulses 4 edges after accept; MTX00=19, MTX01=22, MTX10=43, MTX11=50.
- All coefficients 15, ACC=0 -> all MTX=450. Repeat with ACC=1 -> all MTX=900. Repeat again with ACC=1 -> all MTX=326 (1350 mod 1024).
- START held high continuously with the identity matrix for A and B=[[2,3],[4,5]] -> DONE every 4th cycle; MTX=[[2,3],[4,5]] each time.
- START pulsed again at the XFER and MUL cycles with different A/B -> ignored; exactly one DONE; the result matches the first operands.
- RST=1 during the MUL cycle -> next cycle all MTX=0, BUSY=0; DONE never asserts for the aborted operation.
- HIPERCUBO_SIGNED_EN defined, all coefficients 4'h8 (-8) -> all MTX=128. A=[[-1,0],[0,-1]], B=[[3,4],[5,6]] -> MTX=[[-3,-4],[-5,-6]], i.e. 10'h3FD, 10'h3FC, 10'h3FB, 10'h3FA.
